// File: rtl/bus_slave_responder.sv
// Slave-side handshake responder with a small register-file memory.
// Answers controller strobes with ready/response/split after WAIT_CYC wait states.
module bus_slave_responder #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 12,
    parameter int WAIT_CYC = 2,
    parameter int DATA_TMO = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              aout,
    input  logic              dout,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic [1:0]        response,
    output logic              split
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;
    localparam logic [1:0] RESP_WAIT = 2'b10;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [3:0]        wcnt;
    logic [3:0]        tcnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic addr_ok;
    logic accept;
    logic mem_wr;
    logic mem_rd;
    logic tdec;

    assign addr_ok = (int'(addr_in) < DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort on deselect outranks completion, so a dropped sel never writes memory.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        tdec      = 1'b0;
        ready     = 1'b1;
        response  = RESP_OKAY;
        split     = 1'b1;
        case (state)
            IDLE: begin
                split = 1'b0;
                if (sel && aout) begin
                    accept    = 1'b1;
                    state_nxt = addr_ok ? WAIT : ERR;
                end
            end
            WAIT: begin
                ready    = 1'b0;
                response = RESP_WAIT;
                if (!sel) begin
                    state_nxt = IDLE;
                end else if (wcnt == 4'd0) begin
                    if (!rw_q) begin
                        mem_rd    = 1'b1;
                        state_nxt = DONE;
                    end else if (dout) begin
                        mem_wr    = 1'b1;
                        state_nxt = DONE;
                    end else if (tcnt == 4'd0) begin
                        state_nxt = ERR;
                    end else begin
                        tdec = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                response  = RESP_ERR;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            rw_q   <= 1'b0;
            wcnt   <= 4'd0;
            tcnt   <= 4'd0;
            rdata  <= '0;
        end else begin
            if (accept) begin
                addr_q <= addr_in;
                rw_q   <= read_write;
                if (addr_ok) begin
                    wcnt <= 4'(WAIT_CYC);
                    tcnt <= 4'(DATA_TMO);
                end
            end else if (state == WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (tdec) begin
                tcnt <= tcnt - 4'd1;
            end
            if (mem_rd) begin
                rdata <= mem[addr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_wr) begin
            mem[addr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Bench for bus_slave_responder: table of transfers scored through a queue,
// plus hand-written sequences for abort and asynchronous reset.
module tb_bus_slave_responder;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 12;
    localparam int WAIT_CYC = 2;
    localparam int DATA_TMO = 8;
    localparam int NEVER    = 99;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sel = 1'b0;
    logic              aout = 1'b0;
    logic              dout = 1'b0;
    logic              read_write = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [1:0]        response;
    logic              split;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] wd;
        int                dly;
        logic              poke;
        logic [1:0]        exp_resp;
        int                exp_wait;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    vec_t sbq[$];

    bus_slave_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .WAIT_CYC(WAIT_CYC), .DATA_TMO(DATA_TMO)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .aout(aout), .dout(dout),
        .read_write(read_write), .addr_in(addr_in), .wdata(wdata),
        .rdata(rdata), .ready(ready), .response(response), .split(split)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [ADDR_W-1:0] a, input logic rw, input logic [DATA_W-1:0] wd,
                                input int dly, input logic poke, input logic [1:0] er,
                                input int ew, input logic [DATA_W-1:0] erd);
        vec_t v;
        v.addr = a; v.rw = rw; v.wd = wd; v.dly = dly; v.poke = poke;
        v.exp_resp = er; v.exp_wait = ew; v.exp_rdata = erd;
        return v;
    endfunction

    // Issue one request, count WAIT cycles, score the terminal cycle, then the IDLE cycle.
    task automatic xfer(input string tag, input vec_t v);
        int   j;
        bit   done;
        vec_t e;
        @(negedge clk);
        sel = 1'b1; aout = 1'b1; addr_in = v.addr; read_write = v.rw; wdata = v.wd; dout = 1'b0;
        sbq.push_back(v);
        @(negedge clk);
        aout = 1'b0;
        j = 0;
        done = 1'b0;
        while (!done && j < 40) begin
            if (!ready && response == 2'b10 && split) begin
                dout = (j >= v.dly);
                j++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check({tag, " terminal_reached"}, 32'(0), 32'(1));
        end
        if (sbq.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, 32'(0), 32'(1));
        end else begin
            e = sbq.pop_front();
            check({tag, " response"}, 32'(response), 32'(e.exp_resp));
            check({tag, " ready_split"}, {30'd0, ready, split}, 32'h3);
            check({tag, " wait_cycles"}, 32'(j), 32'(e.exp_wait));
            check({tag, " rdata"}, 32'(rdata), 32'(e.exp_rdata));
        end
        dout = 1'b0;
        if (v.poke) begin
            sel = 1'b1; aout = 1'b1; addr_in = 4'd4; read_write = 1'b0;
        end else begin
            sel = 1'b0;
        end
        @(negedge clk);
        sel = 1'b0; aout = 1'b0;
        check({tag, " idle_after"}, {28'd0, ready, response, split}, 32'h8);
    endtask

    // Write with dout held, drop sel at WAIT cycle index drop_at; must return to IDLE with no write.
    task automatic abort_write(input string tag, input logic [ADDR_W-1:0] a, input int drop_at);
        @(negedge clk);
        sel = 1'b1; aout = 1'b1; addr_in = a; read_write = 1'b1; wdata = 8'h77; dout = 1'b1;
        @(negedge clk);
        aout = 1'b0;
        for (int k = 0; k < drop_at; k++) @(negedge clk);
        check({tag, " in_wait"}, {28'd0, ready, response, split}, 32'h5);
        sel = 1'b0;
        @(negedge clk);
        dout = 1'b0;
        check({tag, " idle_after_abort"}, {28'd0, ready, response, split}, 32'h8);
    endtask

    initial begin
        vecs.push_back(mk(4'd3,  1'b1, 8'hA5, 0,     1'b1, 2'b00, 3,  8'h00));
        vecs.push_back(mk(4'd3,  1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'hA5));
        vecs.push_back(mk(4'd13, 1'b0, 8'h00, 0,     1'b1, 2'b01, 0,  8'hA5));
        vecs.push_back(mk(4'd5,  1'b1, 8'h11, NEVER, 1'b0, 2'b01, 11, 8'hA5));
        vecs.push_back(mk(4'd5,  1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'h00));
        vecs.push_back(mk(4'd7,  1'b1, 8'h3C, 5,     1'b0, 2'b00, 6,  8'h00));
        vecs.push_back(mk(4'd0,  1'b1, 8'hFF, 1,     1'b0, 2'b00, 3,  8'h00));
        vecs.push_back(mk(4'd7,  1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'h3C));
        vecs.push_back(mk(4'd11, 1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'h00));
        vecs.push_back(mk(4'd12, 1'b1, 8'h99, 0,     1'b0, 2'b01, 0,  8'h00));
        vecs.push_back(mk(4'd11, 1'b1, 8'h5A, 10,    1'b0, 2'b00, 11, 8'h00));
        vecs.push_back(mk(4'd11, 1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'h5A));
        vecs.push_back(mk(4'd15, 1'b0, 8'h00, 0,     1'b0, 2'b01, 0,  8'h5A));
        vecs.push_back(mk(4'd0,  1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'hFF));
        vecs.push_back(mk(4'd4,  1'b0, 8'h00, 0,     1'b0, 2'b00, 3,  8'h00));

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, ready, response, split, rdata}, {20'd0, 4'h8, 8'h00});
        rst = 1'b1;

        foreach (vecs[i]) xfer($sformatf("vec%0d", i), vecs[i]);

        abort_write("abort_wait1", 4'd2, 1);
        xfer("read_after_abort1", mk(4'd2, 1'b0, 8'h00, 0, 1'b0, 2'b00, 3, 8'h00));
        abort_write("abort_wait2", 4'd2, 2);
        xfer("read_after_abort2", mk(4'd2, 1'b0, 8'h00, 0, 1'b0, 2'b00, 3, 8'h00));

        // Seed rdata with a non-zero value, then reset during a write's WAIT phase.
        xfer("seed_read", mk(4'd0, 1'b0, 8'h00, 0, 1'b0, 2'b00, 3, 8'hFF));
        @(negedge clk);
        sel = 1'b1; aout = 1'b1; addr_in = 4'd9; read_write = 1'b1; wdata = 8'hC3; dout = 1'b1;
        @(negedge clk);
        aout = 1'b0;
        @(negedge clk);
        check("pre_reset_wait", {28'd0, ready, response, split}, 32'h5);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {20'd0, ready, response, split, rdata}, {20'd0, 4'h8, 8'h00});
        sel = 1'b0; dout = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xfer("read_after_reset_a9", mk(4'd9, 1'b0, 8'h00, 0, 1'b0, 2'b00, 3, 8'h00));
        xfer("read_after_reset_a3", mk(4'd3, 1'b0, 8'h00, 0, 1'b0, 2'b00, 3, 8'h00));

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
